// File: rtl/branch_resolve_bht.sv
// Branch resolve stage with a 2-bit bimodal history table.
// Resolves the branch condition, registers the redirect/mispredict result and trains the table.
module branch_resolve_bht #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [DATA_W-1:0] res_a,
  input  logic [DATA_W-1:0] res_b,
  input  logic [3:0]        res_cond,
  input  logic              res_pred,
  input  logic [31:0]       res_target,
  input  logic [31:0]       res_fall,
  output logic              out_valid,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic [31:0]       out_redirect_pc,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  typedef enum logic [3:0] {
    CondEq    = 4'b0000,
    CondNe    = 4'b0001,
    CondGez   = 4'b0010,
    CondGtz   = 4'b0011,
    CondLez   = 4'b0100,
    CondLtz   = 4'b0101,
    CondGezal = 4'b0110,
    CondLtzal = 4'b0111,
    CondAlways = 4'b1000
  } cond_e;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;

  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic             out_mispredict_q, out_mispredict_d;
  logic [31:0]      out_redirect_q, out_redirect_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic             a_zero;
  logic             a_neg;
  logic             cond_taken;
  logic             is_branch;
  logic             is_conditional;
  logic             accepted;
  logic             mispredict;
  logic             tbl_we;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic             unusedPcBits;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign res_idx  = res_pc[IDX_W+1:2];
  assign unusedPcBits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0]};

  // Read-before-write: an update this cycle is seen by the next prediction only.
  assign pred_taken = bht_q[pred_idx][1];

  assign a_zero = (res_a == '0);
  assign a_neg  = res_a[DATA_W-1];

  always_comb begin
    cond_taken = 1'b0;
    case (res_cond)
      CondEq:     cond_taken = (res_a == res_b);
      CondNe:     cond_taken = (res_a != res_b);
      CondGez:    cond_taken = !a_neg;
      CondGtz:    cond_taken = !a_neg && !a_zero;
      CondLez:    cond_taken = a_neg || a_zero;
      CondLtz:    cond_taken = a_neg;
      CondGezal:  cond_taken = !a_neg;
      CondLtzal:  cond_taken = a_neg;
      CondAlways: cond_taken = 1'b1;
      default:    cond_taken = 1'b0;
    endcase
  end

  assign is_branch      = (res_cond <= CondAlways);
  assign is_conditional = !res_cond[3];
  assign accepted       = res_valid && !stall && !flush && is_branch;
  assign mispredict     = cond_taken != res_pred;
  assign tbl_we         = accepted && is_conditional;

  // Saturating 2-bit counter step toward the resolved direction.
  assign ctr_cur = bht_q[res_idx];
  always_comb begin
    ctr_next = ctr_cur;
    if (cond_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (tbl_we) begin
      bht_q[res_idx] <= ctr_next;
    end
  end

  // Stall holds everything; otherwise valid/mispredict pulse and the payload holds when idle.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_mispredict_d = out_mispredict_q;
    out_redirect_d   = out_redirect_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (!stall) begin
      out_valid_d      = accepted;
      out_mispredict_d = accepted && mispredict;
      if (accepted) begin
        out_taken_d    = cond_taken;
        out_redirect_d = cond_taken ? res_target : res_fall;
        if (mispredict && (mispredict_cnt_q != {CNT_W{1'b1}}))
          mispredict_cnt_d = mispredict_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
      out_redirect_q   <= 32'h0;
      mispredict_cnt_q <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_mispredict_q <= out_mispredict_d;
      out_redirect_q   <= out_redirect_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_taken       = out_taken_q;
  assign out_mispredict  = out_mispredict_q;
  assign out_redirect_pc = out_redirect_q;
  assign mispredict_cnt  = mispredict_cnt_q;

endmodule

// File: doc/branch_resolve_bht.md
BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the compare operands a/b.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, power of 2 only: number of 2-bit counters; IDX_W = log2(BHT_DEPTH).
REQ-003 SHALL have parameter CNT_W, default 16: width of the mispredict statistics counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports are clk and resetn.
REQ-005 SHALL have these ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- stall  in  1  freeze all registers and the table
- flush  in  1  kill the resolve in flight this cycle
- pred_pc  in  32  fetch PC to predict
- pred_taken  out  1  combinational prediction
- res_valid  in  1  resolve request
- res_pc  in  32  branch PC
- res_a, res_b  in  DATA_W  operands
- res_cond  in  4  condition code
- res_pred  in  1  prediction made at fetch
- res_target  in  32  taken target
- res_fall  in  32  fall-through PC
- out_valid  out  1  registered result valid
- out_taken  out  1  resolved direction
- out_mispredict  out  1  out_taken != res_pred
- out_redirect_pc  out  32  correct next PC
- mispredict_cnt  out  CNT_W  saturating mispredict count

Function
REQ-006 SHALL index the table with PC[IDX_W+1:2], for both pred_pc and res_pc.
REQ-007 SHALL drive pred_taken = MSB of the counter at the pred_pc index, read combinationally.
- No bypass: a same-cycle update at the same index is not visible until the next cycle.
REQ-008 SHALL decode res_cond, with a and b signed DATA_W:
- 0000 a==b; 0001 a!=b
- 0010 a>=0; 0011 a>0; 0100 a<=0; 0101 a<0
- 0110 a>=0 (BGEZAL); 0111 a<0 (BLTZAL)
- 1000 unconditional, always taken
- 1001-1111 not-a-branch
REQ-009 SHALL define an accepted resolve as res_valid && !stall && !flush && res_cond <= 1000.
REQ-010 SHALL, on an accepted resolve, register on the next rising edge:
- out_valid=1
- out_taken = condition result
- out_mispredict = (taken != res_pred)
- out_redirect_pc = taken ? res_target : res_fall
- Latency is exactly 1 cycle.
REQ-011 SHALL, on a cycle with no accepted resolve and stall=0, register out_valid=0, out_mispredict=0; out_taken and out_redirect_pc hold their values.
REQ-012 SHALL, while stall=1, hold all outputs, table entries and the counter unchanged, regardless of flush or res_valid.
REQ-013 SHALL, on an accepted resolve with a conditional code (0000-0111), update the indexed counter on the same edge:
- taken: +1, saturating at 11
- not taken: -1, saturating at 00
REQ-014 SHALL NOT update any counter for code 1000, for not-a-branch codes, or for a flushed request.
REQ-015 SHALL increment mispredict_cnt by 1 on each edge that registers out_mispredict=1, saturating at all-ones with no wrap.
REQ-016 SHALL produce no X on any output for any res_cond value.

Reset
REQ-017 SHALL, while resetn=0, immediately force:
- every counter to 01 (weakly not taken)
- out_valid=0, out_taken=0, out_mispredict=0, out_redirect_pc=0
- mispredict_cnt=0
REQ-018 SHALL, on reset assertion mid-operation, discard the resolve in flight with no table update; the first accepted resolve after resetn rises completes normally.

Verification
REQ-019 SHALL cover these directed scenarios:
- Reset, pred_pc=0x100 -> pred_taken=0; all outputs 0.
- BEQ a=5 b=5 pred=0 tgt=0x200 fall=0x104 -> next cycle out_valid=1 taken=1 mispredict=1 redirect=0x200; mispredict_cnt=1; counter 01->10, so pred_taken at 0x100 becomes 1.
- BLTZ a=0x80000000 three times at the same PC -> counter saturates at 11; a fourth not-taken resolve moves it to 10 and pred_taken stays 1.
- Flush with res_valid and stall both asserted -> no change; stall=0 flush=1 -> out_valid=0, no counter change.
- res_cond=1010 -> out_valid=0, no update; res_cond=1000 pred=1 -> taken=1, mispredict=0, counter unchanged.
- CNT_W=2, four mispredicts -> mispredict_cnt reads 1,2,3,3.
